// File: rtl/cpu_pkg.sv
// Shared RV32I core definitions: opcodes, control encodings and the packed
// decoder control bundle carried across the ID/EX boundary.
package cpu_pkg;

   // Base opcodes (instr[6:0])
   localparam logic [6:0] OP_RTYPE   = 7'b0110011;
   localparam logic [6:0] OP_ITYPE_L = 7'b0000011;
   localparam logic [6:0] OP_ITYPE_R = 7'b0010011;
   localparam logic [6:0] OP_STYPE   = 7'b0100011;
   localparam logic [6:0] OP_BTYPE   = 7'b1100011;
   localparam logic [6:0] OP_JAL     = 7'b1101111;
   localparam logic [6:0] OP_JALR    = 7'b1100111;
   localparam logic [6:0] OP_LUI     = 7'b0110111;
   localparam logic [6:0] OP_AUIPC   = 7'b0010111;

   // ALU operation that does nothing
   localparam logic [4:0] ALUOP_NOP = 5'b00000;

   // Writeback source select
   localparam logic [1:0] WDSEL_FROM_ALU = 2'b00;
   localparam logic [1:0] WDSEL_FROM_MEM = 2'b01;
   localparam logic [1:0] WDSEL_FROM_PC  = 2'b10;

   // Data memory access width
   localparam logic [2:0] DM_WORD   = 3'b000;
   localparam logic [2:0] DM_HALF   = 3'b001;
   localparam logic [2:0] DM_HALF_U = 3'b010;
   localparam logic [2:0] DM_BYTE   = 3'b011;
   localparam logic [2:0] DM_BYTE_U = 3'b100;

   // Every decoder control field; all-zero is a harmless bubble
   typedef struct packed {
      logic       RegWrite;
      logic       MemWrite;
      logic       MemRead;
      logic       ALUSrc;
      logic       sbtype;
      logic       jal;
      logic       jalr;
      logic [5:0] EXTOp;
      logic [4:0] ALUOp;
      logic [1:0] WDSel;
      logic [2:0] DMType;
   } ctrl_bundle_t;

   localparam ctrl_bundle_t CTRL_NOP = '{
      RegWrite: 1'b0, MemWrite: 1'b0, MemRead: 1'b0, ALUSrc: 1'b0,
      sbtype: 1'b0, jal: 1'b0, jalr: 1'b0, EXTOp: 6'd0,
      ALUOp: ALUOP_NOP, WDSel: WDSEL_FROM_ALU, DMType: DM_WORD};

   // rs1 is read by everything except the U-types and jal
   function automatic logic op_uses_rs1(input logic [6:0] op);
      return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
   endfunction

   // rs2 is read only by register-register ALU ops, stores and branches
   function automatic logic op_uses_rs2(input logic [6:0] op);
      return (op == OP_RTYPE) || (op == OP_STYPE) || (op == OP_BTYPE);
   endfunction

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detection for the ID/EX boundary. Purely combinational:
// compares the ID source registers against a load sitting in EX and derives
// the IF/ID stall and bubble-insert strobes, honouring flush and hold.
module hazard_unit
   import cpu_pkg::*;
#(
   parameter int RIDX_W = 5
) (
   input  logic              i_id_valid,
   input  logic [6:0]        i_id_op,
   input  logic [RIDX_W-1:0] i_id_rs1,
   input  logic [RIDX_W-1:0] i_id_rs2,
   input  logic              i_ex_valid,
   input  logic              i_ex_mem_read,
   input  logic [RIDX_W-1:0] i_ex_rd,
   input  logic              i_flush,
   input  logic              i_hold,
   output logic              o_load_use,
   output logic              o_stall_ifid,
   output logic              o_bubble
);

   logic w_uses_rs1;
   logic w_uses_rs2;
   logic w_rs1_hit;
   logic w_rs2_hit;
   logic w_ex_is_load;

   // Decode source usage and match against a pending load destination (x0 never hazards)
   always_comb begin
      w_uses_rs1   = op_uses_rs1(i_id_op);
      w_uses_rs2   = op_uses_rs2(i_id_op);
      w_ex_is_load = i_ex_valid & i_ex_mem_read & (i_ex_rd != '0);
      w_rs1_hit    = w_uses_rs1 & (i_ex_rd == i_id_rs1);
      w_rs2_hit    = w_uses_rs2 & (i_ex_rd == i_id_rs2);
      o_load_use   = i_id_valid & w_ex_is_load & (w_rs1_hit | w_rs2_hit);
      // A flush kills the ID instruction, so only hold keeps IF/ID frozen then
      o_stall_ifid = (o_load_use & ~i_flush) | i_hold;
      o_bubble     = o_load_use & ~i_flush & ~i_hold;
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32I core. Captures the decoded
// control bundle, operands and register indices, inserting bubbles on
// load-use hazards and flushes, and freezing on global hold.
// Optional event counters are built when ID_EX_PERF_CNT_EN is defined.
module id_ex_stage
   import cpu_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int RIDX_W = 5
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              id_valid,
   input  logic [6:0]        id_op,
   input  logic              id_RegWrite,
   input  logic              id_MemWrite,
   input  logic              id_MemRead,
   input  logic              id_ALUSrc,
   input  logic              id_sbtype,
   input  logic              id_jal,
   input  logic              id_jalr,
   input  logic [5:0]        id_EXTOp,
   input  logic [4:0]        id_ALUOp,
   input  logic [1:0]        id_WDSel,
   input  logic [2:0]        id_DMType,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [XLEN-1:0]   id_rs1_data,
   input  logic [XLEN-1:0]   id_rs2_data,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [RIDX_W-1:0] id_rs1,
   input  logic [RIDX_W-1:0] id_rs2,
   input  logic [RIDX_W-1:0] id_rd,
   input  logic              flush,
   input  logic              hold,
   output logic              ex_RegWrite,
   output logic              ex_MemWrite,
   output logic              ex_MemRead,
   output logic              ex_ALUSrc,
   output logic              ex_sbtype,
   output logic              ex_jal,
   output logic              ex_jalr,
   output logic [5:0]        ex_EXTOp,
   output logic [4:0]        ex_ALUOp,
   output logic [1:0]        ex_WDSel,
   output logic [2:0]        ex_DMType,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_rs1_data,
   output logic [XLEN-1:0]   ex_rs2_data,
   output logic [XLEN-1:0]   ex_imm,
   output logic [RIDX_W-1:0] ex_rs1,
   output logic [RIDX_W-1:0] ex_rs2,
   output logic [RIDX_W-1:0] ex_rd,
   output logic              ex_valid,
   output logic              stall_ifid,
   output logic              bubble
`ifdef ID_EX_PERF_CNT_EN
  ,output logic [31:0]       perf_bubbles,
   output logic [31:0]       perf_flushes
`endif
);

   ctrl_bundle_t      r_ctrl;
   logic              r_valid;
   logic [XLEN-1:0]   r_pc;
   logic [XLEN-1:0]   r_rs1_data;
   logic [XLEN-1:0]   r_rs2_data;
   logic [XLEN-1:0]   r_imm;
   logic [RIDX_W-1:0] r_rs1;
   logic [RIDX_W-1:0] r_rs2;
   logic [RIDX_W-1:0] r_rd;

   ctrl_bundle_t      w_id_ctrl;
   logic              w_load_use;
   logic              w_stall_ifid;
   logic              w_bubble;

   // Pack the decoder controls; an empty ID slot contributes no side effects
   always_comb begin
      w_id_ctrl = CTRL_NOP;
      if (id_valid) begin
         w_id_ctrl.RegWrite = id_RegWrite;
         w_id_ctrl.MemWrite = id_MemWrite;
         w_id_ctrl.MemRead  = id_MemRead;
         w_id_ctrl.ALUSrc   = id_ALUSrc;
         w_id_ctrl.sbtype   = id_sbtype;
         w_id_ctrl.jal      = id_jal;
         w_id_ctrl.jalr     = id_jalr;
         w_id_ctrl.EXTOp    = id_EXTOp;
         w_id_ctrl.ALUOp    = id_ALUOp;
         w_id_ctrl.WDSel    = id_WDSel;
         w_id_ctrl.DMType   = id_DMType;
      end
   end

   hazard_unit #(
      .RIDX_W (RIDX_W)
   ) u_hazard (
      .i_id_valid    (id_valid),
      .i_id_op       (id_op),
      .i_id_rs1      (id_rs1),
      .i_id_rs2      (id_rs2),
      .i_ex_valid    (r_valid),
      .i_ex_mem_read (r_ctrl.MemRead),
      .i_ex_rd       (r_rd),
      .i_flush       (flush),
      .i_hold        (hold),
      .o_load_use    (w_load_use),
      .o_stall_ifid  (w_stall_ifid),
      .o_bubble      (w_bubble)
   );

   // Control/valid register: flush beats hold, hold beats load-use bubble
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_ctrl  <= CTRL_NOP;
         r_valid <= 1'b0;
      end else if (flush) begin
         r_ctrl  <= CTRL_NOP;
         r_valid <= 1'b0;
      end else if (!hold) begin
         if (w_load_use) begin
            r_ctrl  <= CTRL_NOP;
            r_valid <= 1'b0;
         end else begin
            r_ctrl  <= w_id_ctrl;
            r_valid <= id_valid;
         end
      end
   end

   // Data fields follow ID whenever the stage advances; with controls zeroed they are inert
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_pc       <= '0;
         r_rs1_data <= '0;
         r_rs2_data <= '0;
         r_imm      <= '0;
         r_rs1      <= '0;
         r_rs2      <= '0;
         r_rd       <= '0;
      end else if (flush || !hold) begin
         r_pc       <= id_pc;
         r_rs1_data <= id_rs1_data;
         r_rs2_data <= id_rs2_data;
         r_imm      <= id_imm;
         r_rs1      <= id_rs1;
         r_rs2      <= id_rs2;
         r_rd       <= id_rd;
      end
   end

`ifdef ID_EX_PERF_CNT_EN
   logic [31:0] r_perf_bubbles;
   logic [31:0] r_perf_flushes;

   // Free-running event counters; wrap naturally at 2^32
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_perf_bubbles <= '0;
         r_perf_flushes <= '0;
      end else begin
         if (w_bubble)
            r_perf_bubbles <= r_perf_bubbles + 32'd1;
         if (flush && id_valid)
            r_perf_flushes <= r_perf_flushes + 32'd1;
      end
   end

   assign perf_bubbles = r_perf_bubbles;
   assign perf_flushes = r_perf_flushes;
`endif

   assign ex_RegWrite = r_ctrl.RegWrite;
   assign ex_MemWrite = r_ctrl.MemWrite;
   assign ex_MemRead  = r_ctrl.MemRead;
   assign ex_ALUSrc   = r_ctrl.ALUSrc;
   assign ex_sbtype   = r_ctrl.sbtype;
   assign ex_jal      = r_ctrl.jal;
   assign ex_jalr     = r_ctrl.jalr;
   assign ex_EXTOp    = r_ctrl.EXTOp;
   assign ex_ALUOp    = r_ctrl.ALUOp;
   assign ex_WDSel    = r_ctrl.WDSel;
   assign ex_DMType   = r_ctrl.DMType;
   assign ex_pc       = r_pc;
   assign ex_rs1_data = r_rs1_data;
   assign ex_rs2_data = r_rs2_data;
   assign ex_imm      = r_imm;
   assign ex_rs1      = r_rs1;
   assign ex_rs2      = r_rs2;
   assign ex_rd       = r_rd;
   assign ex_valid    = r_valid;
   assign stall_ifid  = w_stall_ifid;
   assign bubble      = w_bubble;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a vector table stepped one clock per row,
// plus a hand-written asynchronous reset sequence. Perf counter checks are
// compiled in when ID_EX_PERF_CNT_EN is defined.
module tb_id_ex_stage;
   import cpu_pkg::*;

   logic        clk;
   logic        rstn;
   logic        id_valid;
   logic [6:0]  id_op;
   logic        id_RegWrite, id_MemWrite, id_MemRead, id_ALUSrc, id_sbtype, id_jal, id_jalr;
   logic [5:0]  id_EXTOp;
   logic [4:0]  id_ALUOp;
   logic [1:0]  id_WDSel;
   logic [2:0]  id_DMType;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        flush, hold;
   logic        ex_RegWrite, ex_MemWrite, ex_MemRead, ex_ALUSrc, ex_sbtype, ex_jal, ex_jalr;
   logic [5:0]  ex_EXTOp;
   logic [4:0]  ex_ALUOp;
   logic [1:0]  ex_WDSel;
   logic [2:0]  ex_DMType;
   logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic        ex_valid, stall_ifid, bubble;
`ifdef ID_EX_PERF_CNT_EN
   logic [31:0] perf_bubbles, perf_flushes;
`endif

   id_ex_stage dut (
      .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_op(id_op),
      .id_RegWrite(id_RegWrite), .id_MemWrite(id_MemWrite), .id_MemRead(id_MemRead),
      .id_ALUSrc(id_ALUSrc), .id_sbtype(id_sbtype), .id_jal(id_jal), .id_jalr(id_jalr),
      .id_EXTOp(id_EXTOp), .id_ALUOp(id_ALUOp), .id_WDSel(id_WDSel), .id_DMType(id_DMType),
      .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush), .hold(hold),
      .ex_RegWrite(ex_RegWrite), .ex_MemWrite(ex_MemWrite), .ex_MemRead(ex_MemRead),
      .ex_ALUSrc(ex_ALUSrc), .ex_sbtype(ex_sbtype), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
      .ex_EXTOp(ex_EXTOp), .ex_ALUOp(ex_ALUOp), .ex_WDSel(ex_WDSel), .ex_DMType(ex_DMType),
      .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_valid(ex_valid),
      .stall_ifid(stall_ifid), .bubble(bubble)
`ifdef ID_EX_PERF_CNT_EN
     ,.perf_bubbles(perf_bubbles), .perf_flushes(perf_flushes)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Opcodes widened for the table builder
   localparam logic [31:0] OR_ = {25'd0, OP_RTYPE};
   localparam logic [31:0] OL_ = {25'd0, OP_ITYPE_L};
   localparam logic [31:0] OI_ = {25'd0, OP_ITYPE_R};
   localparam logic [31:0] OS_ = {25'd0, OP_STYPE};
   localparam logic [31:0] OU_ = {25'd0, OP_LUI};
   localparam logic [31:0] OJ_ = {25'd0, OP_JAL};

   // Side controls driven constant on every row: {ALUSrc,sbtype,jal,jalr,EXTOp,WDSel,DMType}
   localparam logic [31:0] SIDE_K = {17'd0, 1'b1, 1'b1, 1'b0, 1'b1, 6'h15, 2'b01, 3'b010};

   typedef struct {
      logic        v;
      logic [6:0]  op;
      logic [4:0]  alu;
      logic        rw, mw, mr;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] pc;
      logic        fl, hd;
      logic        e_st, e_bb, e_v;
      logic [4:0]  e_alu;
      logic        e_rw, e_mw, e_mr;
      logic        chk_data;
      logic [4:0]  e_rd;
      logic [31:0] e_pc;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(
      input logic [31:0] v, op, alu, rw, mw, mr, rd, rs1, rs2, pc, fl, hd,
      input logic [31:0] est, ebb, ev, ealu, erw, emw, emr, cd, erd, epc);
      vec_t r;
      r.v = v[0];   r.op = op[6:0];   r.alu = alu[4:0];
      r.rw = rw[0]; r.mw = mw[0];     r.mr = mr[0];
      r.rd = rd[4:0]; r.rs1 = rs1[4:0]; r.rs2 = rs2[4:0];
      r.pc = pc;    r.fl = fl[0];     r.hd = hd[0];
      r.e_st = est[0]; r.e_bb = ebb[0]; r.e_v = ev[0];
      r.e_alu = ealu[4:0]; r.e_rw = erw[0]; r.e_mw = emw[0]; r.e_mr = emr[0];
      r.chk_data = cd[0]; r.e_rd = erd[4:0]; r.e_pc = epc;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      id_valid    = t.v;    id_op = t.op;     id_ALUOp = t.alu;
      id_RegWrite = t.rw;   id_MemWrite = t.mw; id_MemRead = t.mr;
      id_rd       = t.rd;   id_rs1 = t.rs1;   id_rs2 = t.rs2;
      id_pc       = t.pc;
      id_rs1_data = t.pc ^ 32'hA5A5_0000;
      id_imm      = t.pc + 32'h0000_1000;
      id_rs2_data = t.pc + 32'd4;
      flush       = t.fl;   hold = t.hd;
   endtask

   initial begin
      vec_t t;
      //          v  op   alu rw mw mr rd rs1 rs2 pc     fl hd  st bb  ev alu rw mw mr cd rd pc
      vecs.push_back(mk(1, OR_, 3, 1, 0, 0, 3, 1, 2, 'h100, 0, 0, 0, 0, 1, 3, 1, 0, 0, 1, 3, 'h100)); // add x3
      vecs.push_back(mk(1, OL_, 1, 1, 0, 1, 5, 1, 0, 'h104, 0, 0, 0, 0, 1, 1, 1, 0, 1, 1, 5, 'h104)); // lw x5
      vecs.push_back(mk(1, OR_, 3, 1, 0, 0, 6, 5, 7, 'h108, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));     // add x6,x5 -> bubble
      vecs.push_back(mk(1, OR_, 3, 1, 0, 0, 6, 5, 7, 'h108, 0, 0, 0, 0, 1, 3, 1, 0, 0, 1, 6, 'h108)); // add retried
      vecs.push_back(mk(1, OL_, 1, 1, 0, 1, 0, 1, 0, 'h10c, 0, 0, 0, 0, 1, 1, 1, 0, 1, 1, 0, 'h10c)); // lw x0
      vecs.push_back(mk(1, OR_, 3, 1, 0, 0, 6, 0, 7, 'h110, 0, 0, 0, 0, 1, 3, 1, 0, 0, 1, 6, 'h110)); // add x6,x0: no hazard
      vecs.push_back(mk(1, OL_, 1, 1, 0, 1, 5, 1, 0, 'h114, 0, 0, 0, 0, 1, 1, 1, 0, 1, 1, 5, 'h114)); // lw x5
      vecs.push_back(mk(1, OU_, 2, 1, 0, 0, 5, 5, 5, 'h118, 0, 0, 0, 0, 1, 2, 1, 0, 0, 1, 5, 'h118)); // lui: rs unused
      vecs.push_back(mk(1, OL_, 1, 1, 0, 1, 5, 1, 0, 'h11c, 0, 0, 0, 0, 1, 1, 1, 0, 1, 1, 5, 'h11c)); // lw x5
      vecs.push_back(mk(1, OI_, 3, 1, 0, 0, 6, 8, 5, 'h120, 0, 0, 0, 0, 1, 3, 1, 0, 0, 1, 6, 'h120)); // addi rs2 field=5
      vecs.push_back(mk(0, OS_, 4, 1, 1, 0, 9, 1, 2, 'h124, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 'h124)); // invalid: gated ctrl
      vecs.push_back(mk(1, OS_, 1, 0, 1, 0, 0, 1, 2, 'h128, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0, 'h128)); // sw
      vecs.push_back(mk(1, OL_, 1, 1, 0, 1, 5, 1, 0, 'h12c, 0, 0, 0, 0, 1, 1, 1, 0, 1, 1, 5, 'h12c)); // lw x5
      vecs.push_back(mk(1, OR_, 3, 1, 0, 0, 6, 5, 7, 'h130, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));     // flush+hold+load_use
      vecs.push_back(mk(1, OL_, 1, 1, 0, 1, 5, 1, 0, 'h134, 0, 0, 0, 0, 1, 1, 1, 0, 1, 1, 5, 'h134)); // lw x5
      vecs.push_back(mk(1, OR_, 3, 1, 0, 0, 7, 1, 2, 'h138, 0, 1, 1, 0, 1, 1, 1, 0, 1, 1, 5, 'h134)); // hold 1
      vecs.push_back(mk(1, OR_, 3, 1, 0, 0, 7, 1, 2, 'h13c, 0, 1, 1, 0, 1, 1, 1, 0, 1, 1, 5, 'h134)); // hold 2
      vecs.push_back(mk(1, OR_, 3, 1, 0, 0, 7, 1, 2, 'h140, 0, 1, 1, 0, 1, 1, 1, 0, 1, 1, 5, 'h134)); // hold 3
      vecs.push_back(mk(1, OR_, 3, 1, 0, 0, 7, 1, 2, 'h140, 0, 0, 0, 0, 1, 3, 1, 0, 0, 1, 7, 'h140)); // hold drops
      vecs.push_back(mk(1, OL_, 1, 1, 0, 1, 5, 1, 0, 'h144, 0, 0, 0, 0, 1, 1, 1, 0, 1, 1, 5, 'h144)); // lw x5
      vecs.push_back(mk(1, OR_, 3, 1, 0, 0, 6, 5, 7, 'h148, 0, 1, 1, 0, 1, 1, 1, 0, 1, 1, 5, 'h144)); // load_use under hold
      vecs.push_back(mk(1, OR_, 3, 1, 0, 0, 6, 5, 7, 'h148, 0, 1, 1, 0, 1, 1, 1, 0, 1, 1, 5, 'h144)); // still held
      vecs.push_back(mk(1, OR_, 3, 1, 0, 0, 6, 5, 7, 'h148, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));     // bubble after hold
      vecs.push_back(mk(1, OR_, 3, 1, 0, 0, 6, 5, 7, 'h148, 0, 0, 0, 0, 1, 3, 1, 0, 0, 1, 6, 'h148)); // add enters
      vecs.push_back(mk(1, OR_, 3, 1, 0, 0, 8, 1, 2, 'h14c, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));     // flush valid
      vecs.push_back(mk(0, OR_, 3, 1, 0, 0, 8, 1, 2, 'h150, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));     // flush invalid
      vecs.push_back(mk(1, OL_, 1, 1, 0, 1, 5, 1, 0, 'h154, 0, 0, 0, 0, 1, 1, 1, 0, 1, 1, 5, 'h154)); // lw x5
      vecs.push_back(mk(1, OS_, 1, 0, 1, 0, 0, 1, 5, 'h158, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));     // sw rs2=x5 hazard
      vecs.push_back(mk(1, OS_, 1, 0, 1, 0, 0, 1, 5, 'h158, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0, 'h158)); // sw enters
      vecs.push_back(mk(1, OL_, 1, 1, 0, 1, 5, 1, 0, 'h15c, 0, 0, 0, 0, 1, 1, 1, 0, 1, 1, 5, 'h15c)); // lw x5
      vecs.push_back(mk(1, OJ_, 2, 1, 0, 0, 1, 5, 5, 'h160, 0, 0, 0, 0, 1, 2, 1, 0, 0, 1, 1, 'h160)); // jal: rs unused

      // Constant side controls and idle inputs
      id_ALUSrc = SIDE_K[14]; id_sbtype = SIDE_K[13]; id_jal = SIDE_K[12]; id_jalr = SIDE_K[11];
      id_EXTOp = SIDE_K[10:5]; id_WDSel = SIDE_K[4:3]; id_DMType = SIDE_K[2:0];
      t = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(t);
      rstn = 1'b0;

      // Reset state before any clock edge
      #2;
      chk("reset ex_valid", 32'(ex_valid), 32'd0);
      chk("reset ex_ALUOp", 32'(ex_ALUOp), 32'd0);
      chk("reset ctrl", {17'd0, ex_RegWrite, ex_MemWrite, ex_MemRead, ex_ALUSrc, ex_sbtype,
                         ex_jal, ex_jalr, ex_EXTOp, ex_WDSel, ex_DMType}, 32'd0);
      chk("reset ex_pc", ex_pc, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // Table: drive row, check combinational strobes mid-cycle, check registers after the edge
      for (int i = 0; i < vecs.size(); i++) begin
         t = vecs[i];
         drive(t);
         @(negedge clk);
         chk($sformatf("row%0d stall_ifid", i), 32'(stall_ifid), 32'(t.e_st));
         chk($sformatf("row%0d bubble", i), 32'(bubble), 32'(t.e_bb));
         @(posedge clk);
         #1;
         chk($sformatf("row%0d ex_valid", i), 32'(ex_valid), 32'(t.e_v));
         chk($sformatf("row%0d ex_ALUOp", i), 32'(ex_ALUOp), 32'(t.e_alu));
         chk($sformatf("row%0d ex_RegWrite", i), 32'(ex_RegWrite), 32'(t.e_rw));
         chk($sformatf("row%0d ex_MemWrite", i), 32'(ex_MemWrite), 32'(t.e_mw));
         chk($sformatf("row%0d ex_MemRead", i), 32'(ex_MemRead), 32'(t.e_mr));
         chk($sformatf("row%0d side_ctrl", i),
             {17'd0, ex_ALUSrc, ex_sbtype, ex_jal, ex_jalr, ex_EXTOp, ex_WDSel, ex_DMType},
             t.e_v ? SIDE_K : 32'd0);
         if (t.chk_data) begin
            chk($sformatf("row%0d ex_rd", i), 32'(ex_rd), 32'(t.e_rd));
            chk($sformatf("row%0d ex_pc", i), ex_pc, t.e_pc);
            chk($sformatf("row%0d ex_imm", i), ex_imm, t.e_pc + 32'h0000_1000);
            chk($sformatf("row%0d ex_rs1_data", i), ex_rs1_data, t.e_pc ^ 32'hA5A5_0000);
         end
         $display("row %0d pc=%h flush=%0b hold=%0b -> stall=%0b ex_valid=%0b ex_ALUOp=%0d ex_rd=%0d",
                  i, t.pc, t.fl, t.hd, t.e_st, ex_valid, ex_ALUOp, ex_rd);
      end

`ifdef ID_EX_PERF_CNT_EN
      chk("perf_bubbles", perf_bubbles, 32'd3);
      chk("perf_flushes", perf_flushes, 32'd2);
`endif

      // Asynchronous reset mid-stream: load a valid add, then pull rstn between edges
      t = mk(1, OR_, 3, 1, 0, 0, 3, 1, 2, 'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(t);
      @(posedge clk);
      #1;
      chk("pre-reset ex_valid", 32'(ex_valid), 32'd1);
      @(negedge clk);
      #1;
      rstn = 1'b0;
      #1;
      chk("async reset ex_valid", 32'(ex_valid), 32'd0);
      chk("async reset ex_ALUOp", 32'(ex_ALUOp), 32'd0);
      chk("async reset ex_RegWrite", 32'(ex_RegWrite), 32'd0);
      chk("async reset ex_rd", 32'(ex_rd), 32'd0);
      chk("async reset ex_pc", ex_pc, 32'd0);
      $display("async reset at t=%0t ex_valid=%0b ex_ALUOp=%0d", $time, ex_valid, ex_ALUOp);
      @(posedge clk);
      #1;
      chk("reset held ex_valid", 32'(ex_valid), 32'd0);
`ifdef ID_EX_PERF_CNT_EN
      chk("reset perf_bubbles", perf_bubbles, 32'd0);
      chk("reset perf_flushes", perf_flushes, 32'd0);
`endif
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      chk("post-reset ex_valid", 32'(ex_valid), 32'd1);
      chk("post-reset ex_rd", 32'(ex_rd), 32'd3);
      chk("post-reset ex_pc", ex_pc, 32'h200);
      $display("post-reset capture ex_valid=%0b ex_rd=%0d ex_pc=%h", ex_valid, ex_rd, ex_pc);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline boundary for the 5-stage RV32I core; sits directly downstream of the instruction-decode control unit.
- Latches decoded control bundle, operands, immediate and register indices into EX on each advancing clock.
- Detects load-use hazards, stalls IF/ID and inserts a bubble.
- Applies branch/jump flush from EX and holds on a global back-pressure stall.

Parameters:
- XLEN, 32, datapath width for PC, operands, immediate.
- RIDX_W, 5, register index width.

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_op  in  7  opcode, used for source-usage decode
- id_RegWrite, id_MemWrite, id_MemRead, id_ALUSrc, id_sbtype, id_jal, id_jalr  in  1 each  decoder controls
- id_EXTOp  in  6  extension select
- id_ALUOp  in  5  ALU op; 5'b00000 = nop
- id_WDSel  in  2  writeback select
- id_DMType  in  3  load/store width
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each  operands
- id_rs1, id_rs2, id_rd  in  RIDX_W each  register indices
- flush  in  1  EX redirect (taken branch/jal/jalr)
- hold  in  1  global stall from MEM/data memory
- ex_* outputs  out  same widths as id_* (all except id_op)  registered bundle
- ex_valid  out  1  EX slot holds a real instruction
- stall_ifid  out  1  combinational: freeze PC and IF/ID
- bubble  out  1  combinational: load-use bubble inserted this cycle

Behaviour:
- Reset (rstn low, async) clears every ex_* output and ex_valid to 0; ALUOp = nop, WDSel = 00, DMType = 000. Reset mid-operation discards the in-flight instruction.
- uses_rs1 = id_op not in {0110111 lui, 0010111 auipc, 1101111 jal}.
- uses_rs2 = id_op in {0110011 R, 0100011 S, 1100011 B}.
- load_use = id_valid & ex_valid & ex_MemRead & (ex_rd != 0) & ((uses_rs1 & ex_rd == id_rs1) | (uses_rs2 & ex_rd == id_rs2)).
- Per-edge priority, highest first:
  1. flush: load bubble (all control 0, ex_valid 0) regardless of hold or load_use.
  2. hold: all ex_* keep their values.
  3. load_use: load bubble.
  4. Otherwise: capture id_* and set ex_valid = id_valid.
- Control bits, including RegWrite and MemWrite, are gated to 0 whenever the captured id_valid = 0; data fields are captured unchanged.
- stall_ifid = (load_use & ~flush) | hold.
- bubble = load_use & ~flush & ~hold.
- Latency: one cycle ID->EX. A stalled instruction re-evaluates load_use every cycle; load_use clears once the load leaves EX.
- Back-to-back load_use with hold asserted: no bubble until hold drops; stall_ifid stays high throughout.
- Register x0 as ex_rd never causes a hazard.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- With the macro defined, add outputs perf_bubbles[31:0] and perf_flushes[31:0].
  - perf_bubbles increments on every edge where bubble = 1.
  - perf_flushes increments on every edge where flush & ex_valid_next_would_have_been_1, i.e. id_valid = 1.
  - Both wrap at 2^32 and reset to 0.
- Without the macro, neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_RTYPE, OP_ITYPE_L, OP_ITYPE_R, OP_STYPE, OP_BTYPE, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC
  - ALUOP_NOP
  - WDSEL_*, DM_* encodings
  - a ctrl_bundle_t struct packing all decoder control fields
- One sub-module, hazard_unit: purely combinational; computes load_use, stall_ifid and bubble from ID indices/opcode and EX state.

Test Plan:
- Reset: assert rstn=0 mid-stream with ex_valid=1 -> all ex_* = 0 immediately, without waiting for a clock edge; ex_ALUOp = 5'b00000.
- Normal flow: add x3,x1,x2 (id_ALUOp=00011, RegWrite=1, rd=3) -> next edge ex_ALUOp=00011, ex_RegWrite=1, ex_rd=3, ex_valid=1; stall_ifid=0.
- Load-use: lw x5 in EX; add x6,x5,x7 in ID -> stall_ifid=1 and bubble=1 for one cycle, ex_valid=0; next edge the add enters EX with ex_rd=6.
- Non-hazards:
  - lw x0 then add x6,x0,x7 -> no stall.
  - lw x5 then lui x5 -> no stall (rs1 unused).
  - lw x5 then addi x6,x8,x5-pattern with rs2=5 -> no stall (I-type rs2 unused).
- Flush priority: flush=1 together with hold=1 and load_use=1 -> next edge ex_valid=0, all control 0; stall_ifid=0 except the hold term, which remains 1.
- Hold: hold=1 for 3 cycles with new id_* values -> ex_* unchanged; on hold drop the pending ID instruction is captured.
- If ID_EX_PERF_CNT_EN is defined: after 2 load-use bubbles and 1 valid flush -> perf_bubbles=2, perf_flushes=1.
